// File: rtl/even_parity_serial_tx.sv
// Framed serial transmitter: accepts a parallel word, sends start, data (LSB first),
// even-parity and stop bits, each held CLKS_PER_BIT clocks.
module even_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              parity_bit,
    output logic              frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // tx_d always carries the level of the bit the next state will present,
    // so the line is registered yet changes exactly on bit boundaries.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        bit_end   = (clk_cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (in_valid) begin
                    shift_d   = in_data;
                    parity_d  = ^in_data;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_PARITY;
                        tx_d      = parity_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_d[0];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    tx_d      = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
            end
        endcase

        // Pulse is registered, so it is raised on entry to the final stop cycle.
        frame_done_d = (state_d == S_STOP) && (clk_cnt_d == CNT_LAST);
        busy_d       = (state_d != S_IDLE);
    end

    assign in_ready   = (state_q == S_IDLE);
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign parity_bit = parity_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Randomized and directed checks of even_parity_serial_tx against a frame-level model
// over three parameterizations (4/2, 8/1, 4/1).
module tb_even_parity_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    int         sel;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    logic rdy_a, tx_a, busy_a, par_a, fd_a;
    logic rdy_b, tx_b, busy_b, par_b, fd_b;
    logic rdy_c, tx_c, busy_c, par_c, fd_c;
    logic v_a, v_b, v_c;
    logic rdy_s, tx_s, busy_s, par_s, fd_s;

    assign v_a = in_valid && (sel == 0);
    assign v_b = in_valid && (sel == 1);
    assign v_c = in_valid && (sel == 2);

    even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(v_a), .in_data(in_data[3:0]),
        .in_ready(rdy_a), .tx_out(tx_a), .busy(busy_a), .parity_bit(par_a), .frame_done(fd_a)
    );
    even_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(v_b), .in_data(in_data),
        .in_ready(rdy_b), .tx_out(tx_b), .busy(busy_b), .parity_bit(par_b), .frame_done(fd_b)
    );
    even_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(v_c), .in_data(in_data[3:0]),
        .in_ready(rdy_c), .tx_out(tx_c), .busy(busy_c), .parity_bit(par_c), .frame_done(fd_c)
    );

    always_comb begin
        rdy_s = rdy_c; tx_s = tx_c; busy_s = busy_c; par_s = par_c; fd_s = fd_c;
        if (sel == 0) begin
            rdy_s = rdy_a; tx_s = tx_a; busy_s = busy_a; par_s = par_a; fd_s = fd_a;
        end else if (sel == 1) begin
            rdy_s = rdy_b; tx_s = tx_b; busy_s = busy_b; par_s = par_b; fd_s = fd_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s sel=%0d got=%0h expected=%0h t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    // Expected line level k cycles into a frame, from the framing rules alone.
    function automatic logic exp_tx(input logic [7:0] w, input int dw, input int cpb, input int k);
        int b;
        b = k / cpb;
        if (b == 0)           return 1'b0;
        else if (b <= dw)     return w[b-1];
        else if (b == dw + 1) return ^w;
        else                  return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_tx"},   32'(tx_s),   32'd1);
        check({tag, "_busy"}, 32'(busy_s), 32'd0);
        check({tag, "_rdy"},  32'(rdy_s),  32'd1);
        check({tag, "_done"}, 32'(fd_s),   32'd0);
    endtask

    task automatic offer(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        check("rdy_idle", 32'(rdy_s), 32'd1);
        @(posedge clk); #1;
    endtask

    // Called in the first frame cycle (just after the accept edge).
    task automatic run_frame(input int dw, input int cpb, input logic [7:0] word,
                             input bit hold, input bit scramble, input logic [7:0] nxt);
        logic [7:0] w;
        logic [7:0] dec;
        int n;
        int b;
        w   = word & 8'((1 << dw) - 1);
        n   = (dw + 3) * cpb;
        dec = '0;
        for (int k = 0; k < n; k++) begin
            if (!hold) in_valid = 1'b0;
            if (scramble) in_data = 8'($urandom);
            check("tx",     32'(tx_s),   32'(exp_tx(w, dw, cpb, k)));
            check("busy",   32'(busy_s), 32'd1);
            check("rdy_bsy", 32'(rdy_s), 32'd0);
            check("done",   32'(fd_s),   (k == n - 1) ? 32'd1 : 32'd0);
            check("parity", 32'(par_s),  32'(^w));
            b = k / cpb;
            if (b >= 1 && b <= dw && (k % cpb) == 0) dec[b-1] = tx_s;
            @(posedge clk); #1;
        end
        if (hold) in_data = nxt;
        check_idle("post");
        check("decode", 32'(dec), 32'(w));
    endtask

    initial begin
        logic [7:0] w;
        int dw;
        int cpb;
        int gap;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sel      = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle("rst");
            check("rst_par", 32'(par_s), 32'd0);
        end
        rst_n = 1'b1;
        sel   = 0;
        @(posedge clk); #1;

        // Reference frame 4'b1011 at two clocks per bit.
        offer(8'h0B);
        run_frame(4, 2, 8'h0B, 1'b0, 1'b0, 8'h00);

        // Every 4-bit word at one clock per bit.
        sel = 2;
        #1;
        for (int i = 0; i < 16; i++) begin
            offer(8'(i));
            run_frame(4, 1, 8'(i), 1'b0, 1'b0, 8'h00);
        end

        // Valid held with junk data during the frame; next word waits for IDLE.
        sel = 0;
        #1;
        offer(8'h05);
        run_frame(4, 2, 8'h05, 1'b1, 1'b1, 8'h09);
        offer(8'h09);
        run_frame(4, 2, 8'h09, 1'b0, 1'b0, 8'h00);

        // Continuous valid, words 3 then C: exactly one idle cycle between frames.
        offer(8'h03);
        run_frame(4, 2, 8'h03, 1'b1, 1'b0, 8'h0C);
        offer(8'h0C);
        run_frame(4, 2, 8'h0C, 1'b0, 1'b0, 8'h00);

        // Reset mid-DATA aborts the frame.
        offer(8'h0A);
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 32'(busy_s), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_tx",   32'(tx_s),   32'd1);
        check("arst_busy", 32'(busy_s), 32'd0);
        check("arst_done", 32'(fd_s),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_idle("after_rst");
            @(posedge clk); #1;
        end
        offer(8'h06);
        run_frame(4, 2, 8'h06, 1'b0, 1'b0, 8'h00);

        // Eight-bit word 8'h80 at one clock per bit: MSB in the 9th frame cycle.
        sel = 1;
        #1;
        offer(8'h80);
        run_frame(8, 1, 8'h80, 1'b0, 1'b0, 8'h00);

        // Random words, instances and idle gaps.
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 2));
            dw  = (sel == 1) ? 8 : 4;
            cpb = (sel == 0) ? 2 : 1;
            w   = 8'($urandom);
            #1;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                check_idle("gap");
                @(posedge clk); #1;
            end
            offer(w);
            run_frame(dw, cpb, w, 1'b0, ($urandom_range(0, 1) == 1), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
